lcd1602_bus_receiver: RTL and testbench

//  HD44780-compatible responder for the LCD1602 8-bit parallel bus (rs/rw/enable/data).

---
 rtl/lcd1602_bus_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_lcd1602_bus_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd1602_bus_receiver
// Description : HD44780-compatible listener on the LCD1602 8-bit bus. Decodes
//               commands and keeps a 2x16 character mirror plus mode flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd1602_bus_receiver #(
    parameter int         DATA_BITS  = 8,
    parameter int         NUM_COLS   = 16,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lcd_rs,
    input  logic                 lcd_rw,
    input  logic                 lcd_e,
    input  logic [DATA_BITS-1:0] lcd_data,
    input  logic [4:0]           rd_addr,
    output logic [7:0]           rd_char,
    output logic [6:0]           cursor_addr,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 entry_inc,
    output logic                 two_line,
    output logic                 busy,
    output logic                 cmd_valid,
    output logic [DATA_BITS-1:0] cmd_code,
    output logic                 err_pulse
);

    localparam int c_DEPTH = 2 * NUM_COLS;

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_CLEAR_FILL = 1'b1
    } state_t;

    // Bus synchronizers and the captured transfer
    logic                 r_e_s1, r_e_s2, r_e_s3;
    logic                 r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
    logic [DATA_BITS-1:0] r_data_s1, r_data_s2;
    logic                 r_xfer_v, r_xfer_rs, r_xfer_rw;
    logic [DATA_BITS-1:0] r_xfer_data;
    logic                 w_strobe;

    state_t               r_state;
    logic [7:0]           r_mirror [c_DEPTH];
    logic [4:0]           r_fill_idx;
    logic [6:0]           r_ac;
    logic                 r_disp, r_curs, r_blink, r_inc, r_two, r_cgram;
    logic                 r_busy, r_cmd_valid, r_err;
    logic [DATA_BITS-1:0] r_cmd_code;
    logic [4:0]           w_widx;
    logic                 w_visible;

    assign w_strobe  = r_e_s3 & ~r_e_s2;
    assign w_widx    = {r_ac[6], r_ac[3:0]};
    assign w_visible = (r_ac[5:4] == 2'b00);

    // Next address counter value; out-of-range addresses restart at 0x00
    function automatic logic [6:0] step_ac(input logic [6:0] ac, input logic inc,
                                           input logic two);
        logic [6:0] nxt;
        nxt = ac;
        if (two) begin
            if (ac > 7'h67 || (ac > 7'h27 && ac < 7'h40)) nxt = 7'h00;
            else if (inc) nxt = (ac == 7'h27) ? 7'h40 : ((ac == 7'h67) ? 7'h00 : ac + 7'd1);
            else          nxt = (ac == 7'h00) ? 7'h67 : ((ac == 7'h40) ? 7'h27 : ac - 7'd1);
        end else begin
            if (ac > 7'h4F) nxt = 7'h00;
            else if (inc) nxt = (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
            else          nxt = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_s1      <= 1'b0;
            r_e_s2      <= 1'b0;
            r_e_s3      <= 1'b0;
            r_rs_s1     <= 1'b0;
            r_rs_s2     <= 1'b0;
            r_rw_s1     <= 1'b0;
            r_rw_s2     <= 1'b0;
            r_data_s1   <= '0;
            r_data_s2   <= '0;
            r_xfer_v    <= 1'b0;
            r_xfer_rs   <= 1'b0;
            r_xfer_rw   <= 1'b0;
            r_xfer_data <= '0;
        end else begin
            r_e_s1    <= lcd_e;
            r_e_s2    <= r_e_s1;
            r_e_s3    <= r_e_s2;
            r_rs_s1   <= lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_rw_s1   <= lcd_rw;
            r_rw_s2   <= r_rw_s1;
            r_data_s1 <= lcd_data;
            r_data_s2 <= r_data_s1;
            r_xfer_v  <= w_strobe;
            if (w_strobe) begin
                r_xfer_rs   <= r_rs_s2;
                r_xfer_rw   <= r_rw_s2;
                r_xfer_data <= r_data_s2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            for (int i = 0; i < c_DEPTH; i++) r_mirror[i] <= BLANK_CHAR;
            r_fill_idx  <= '0;
            r_ac        <= '0;
            r_disp      <= 1'b0;
            r_curs      <= 1'b0;
            r_blink     <= 1'b0;
            r_inc       <= 1'b1;
            r_two       <= 1'b0;
            r_cgram     <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_xfer_v) begin
                        if (r_xfer_rw) begin
                            r_err <= 1'b1;
                        end else if (!r_xfer_rs) begin
                            casez (r_xfer_data)
                                8'b1???????: begin
                                    r_ac    <= r_xfer_data[6:0];
                                    r_cgram <= 1'b0;
                                end
                                8'b01??????: begin
                                    r_cgram <= 1'b1;
                                    r_err   <= 1'b1;
                                end
                                8'b001?????: begin
                                    r_two <= r_xfer_data[3];
                                    if (!r_xfer_data[4]) r_err <= 1'b1;
                                end
                                8'b0001????: begin
                                    if (r_xfer_data[3]) r_err <= 1'b1;
                                    else r_ac <= step_ac(r_ac, r_xfer_data[2], r_two);
                                end
                                8'b00001???: begin
                                    r_disp  <= r_xfer_data[2];
                                    r_curs  <= r_xfer_data[1];
                                    r_blink <= r_xfer_data[0];
                                end
                                8'b000001??: begin
                                    r_inc <= r_xfer_data[1];
                                    if (r_xfer_data[0]) r_err <= 1'b1;
                                end
                                8'b0000001?: begin
                                    r_ac    <= '0;
                                    r_cgram <= 1'b0;
                                end
                                8'b00000001: begin
                                    r_ac       <= '0;
                                    r_inc      <= 1'b1;
                                    r_cgram    <= 1'b0;
                                    r_busy     <= 1'b1;
                                    r_fill_idx <= '0;
                                    r_state    <= ST_CLEAR_FILL;
                                end
                                default: ;
                            endcase
                            if (r_xfer_data != '0) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_code  <= r_xfer_data;
                            end
                        end else if (!r_cgram) begin
                            if (w_visible) r_mirror[w_widx] <= r_xfer_data;
                            r_ac <= step_ac(r_ac, r_inc, r_two);
                        end
                    end
                end
                ST_CLEAR_FILL: begin
                    // Any transfer arriving during the fill is lost
                    if (r_xfer_v) r_err <= 1'b1;
                    r_mirror[r_fill_idx] <= BLANK_CHAR;
                    r_fill_idx <= r_fill_idx + 5'd1;
                    if (r_fill_idx == 5'(c_DEPTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_char     = r_mirror[rd_addr];
    assign cursor_addr = r_ac;
    assign display_on  = r_disp;
    assign cursor_on   = r_curs;
    assign blink_on    = r_blink;
    assign entry_inc   = r_inc;
    assign two_line    = r_two;
    assign busy        = r_busy;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign err_pulse   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd1602_bus_receiver
// Description : Directed table, corner sequences and random transfers checked
//               against a behavioural display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd1602_bus_receiver;

    logic       clk;
    logic       reset;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       display_on, cursor_on, blink_on, entry_inc, two_line, busy;
    logic       cmd_valid, err_pulse;
    logic [7:0] cmd_code;

    lcd1602_bus_receiver dut (
        .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_inc(entry_inc), .two_line(two_line), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cmd_total = 0, err_total = 0, busy_total = 0;

    always @(negedge clk) begin
        if (cmd_valid) cmd_total++;
        if (err_pulse) err_total++;
        if (busy)      busy_total++;
    end

    // Behavioural model of the display controller
    bit [7:0] m_mirror [32];
    int       m_ac;
    bit       m_disp, m_curs, m_blink, m_inc, m_two, m_cgram;
    int       m_code;

    typedef struct {
        bit       rs;
        bit       rw;
        bit [7:0] d;
        bit [6:0] ac;
        bit       err;
        bit       cmd;
    } vec_t;

    vec_t vt [31];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_mirror[i]) m_mirror[i] = 8'h20;
        m_ac = 0; m_disp = 0; m_curs = 0; m_blink = 0;
        m_inc = 1; m_two = 0; m_cgram = 0; m_code = 0;
    endtask

    function automatic int mstep(input int ac, input bit inc, input bit two);
        int base, off, other;
        if (!two) begin
            if (ac > 79) return 0;
            return inc ? (ac + 1) % 80 : (ac + 79) % 80;
        end
        base  = (ac >= 64) ? 64 : 0;
        off   = ac - base;
        other = 64 - base;
        if (off > 39) return 0;
        if (inc) return (off == 39) ? other : ac + 1;
        return (off == 0) ? other + 39 : ac - 1;
    endfunction

    task automatic model_apply(input bit rs, input bit rw, input bit [7:0] d,
                               output bit e_err, output bit e_cmd, output bit e_clr);
        int p;
        e_err = 0; e_cmd = 0; e_clr = 0;
        if (rw) begin
            e_err = 1;
        end else if (rs) begin
            if (!m_cgram) begin
                if ((m_ac % 64) < 16) m_mirror[((m_ac >= 64) ? 16 : 0) + (m_ac % 16)] = d;
                m_ac = mstep(m_ac, m_inc, m_two);
            end
        end else begin
            p = -1;
            for (int b = 7; b >= 0; b--) if (d[b] && p < 0) p = b;
            case (p)
                7: begin m_ac = int'(d[6:0]); m_cgram = 0; end
                6: begin m_cgram = 1; e_err = 1; end
                5: begin m_two = d[3]; e_err = !d[4]; end
                4: if (d[3]) e_err = 1; else m_ac = mstep(m_ac, d[2], m_two);
                3: begin m_disp = d[2]; m_curs = d[1]; m_blink = d[0]; end
                2: begin m_inc = d[1]; e_err = d[0]; end
                1: begin m_ac = 0; m_cgram = 0; end
                0: begin
                    m_ac = 0; m_inc = 1; m_cgram = 0; e_clr = 1;
                    foreach (m_mirror[i]) m_mirror[i] = 8'h20;
                end
                default: ;
            endcase
            if (p >= 0) begin e_cmd = 1; m_code = d; end
        end
    endtask

    task automatic xfer(input bit rs, input bit rw, input bit [7:0] d, input int post);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 100) begin @(negedge clk); i++; end
        chk("idle_wait busy", int'(busy), 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " cursor_addr"}, int'(cursor_addr), m_ac);
        chk({tag, " display_on"}, int'(display_on), int'(m_disp));
        chk({tag, " cursor_on"}, int'(cursor_on), int'(m_curs));
        chk({tag, " blink_on"}, int'(blink_on), int'(m_blink));
        chk({tag, " entry_inc"}, int'(entry_inc), int'(m_inc));
        chk({tag, " two_line"}, int'(two_line), int'(m_two));
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " cmd_code"}, int'(cmd_code), m_code);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            chk($sformatf("%s mirror[%0d]", tag, i), int'(rd_char), int'(m_mirror[i]));
        end
    endtask

    task automatic run_vec(input bit rs, input bit rw, input bit [7:0] d, input string tag,
                           output bit e_err, output bit e_cmd);
        int c0, e0, b0;
        bit e_clr;
        c0 = cmd_total; e0 = err_total; b0 = busy_total;
        xfer(rs, rw, d, 10);
        model_apply(rs, rw, d, e_err, e_cmd, e_clr);
        if (e_clr) wait_idle();
        chk({tag, " err pulses"}, err_total - e0, int'(e_err));
        chk({tag, " cmd pulses"}, cmd_total - c0, int'(e_cmd));
        chk({tag, " busy cycles"}, busy_total - b0, e_clr ? 32 : 0);
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e_err, e_cmd, e_clr;
        int c0, e0, b0, i;

        vt[0]  = '{0, 0, 8'h38, 7'h00, 0, 1};
        vt[1]  = '{0, 0, 8'h06, 7'h00, 0, 1};
        vt[2]  = '{0, 0, 8'h0C, 7'h00, 0, 1};
        vt[3]  = '{0, 0, 8'h01, 7'h00, 0, 1};
        vt[4]  = '{1, 0, 8'h48, 7'h01, 0, 0};
        vt[5]  = '{1, 0, 8'h4F, 7'h02, 0, 0};
        vt[6]  = '{1, 0, 8'h4C, 7'h03, 0, 0};
        vt[7]  = '{1, 0, 8'h41, 7'h04, 0, 0};
        vt[8]  = '{0, 0, 8'hC0, 7'h40, 0, 1};
        vt[9]  = '{1, 0, 8'h35, 7'h41, 0, 0};
        vt[10] = '{0, 0, 8'hA7, 7'h27, 0, 1};
        vt[11] = '{1, 0, 8'h58, 7'h40, 0, 0};
        vt[12] = '{0, 0, 8'h04, 7'h40, 0, 1};
        vt[13] = '{1, 0, 8'h61, 7'h27, 0, 0};
        vt[14] = '{1, 0, 8'h62, 7'h26, 0, 0};
        vt[15] = '{0, 0, 8'h40, 7'h26, 1, 1};
        vt[16] = '{1, 0, 8'h5A, 7'h26, 0, 0};
        vt[17] = '{0, 0, 8'h80, 7'h00, 0, 1};
        vt[18] = '{0, 0, 8'h00, 7'h00, 0, 0};
        vt[19] = '{0, 0, 8'h1C, 7'h00, 1, 1};
        vt[20] = '{0, 0, 8'h10, 7'h67, 0, 1};
        vt[21] = '{0, 0, 8'h14, 7'h00, 0, 1};
        vt[22] = '{0, 0, 8'h28, 7'h00, 1, 1};
        vt[23] = '{0, 0, 8'h05, 7'h00, 1, 1};
        vt[24] = '{0, 0, 8'h30, 7'h00, 0, 1};
        vt[25] = '{0, 0, 8'h10, 7'h4F, 0, 1};
        vt[26] = '{0, 0, 8'h14, 7'h00, 0, 1};
        vt[27] = '{0, 0, 8'hFF, 7'h7F, 0, 1};
        vt[28] = '{0, 0, 8'h14, 7'h00, 0, 1};
        vt[29] = '{0, 0, 8'h02, 7'h00, 0, 1};
        vt[30] = '{0, 1, 8'h80, 7'h00, 1, 0};

        reset = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_e = 0; lcd_data = 0; rd_addr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset cmd_valid", int'(cmd_valid), 0);
        chk("reset err_pulse", int'(err_pulse), 0);
        check_all("reset");

        // Directed table
        for (int k = 0; k < 31; k++) begin
            run_vec(vt[k].rs, vt[k].rw, vt[k].d, $sformatf("tbl%0d", k), e_err, e_cmd);
            chk($sformatf("tbl%0d table cursor_addr", k), int'(cursor_addr), int'(vt[k].ac));
            chk($sformatf("tbl%0d table err", k), int'(e_err), int'(vt[k].err));
            chk($sformatf("tbl%0d table cmd", k), int'(e_cmd), int'(vt[k].cmd));
        end

        // Write while a clear-fill is running is dropped with an error
        run_vec(1, 0, 8'h41, "t5_pre", e_err, e_cmd);
        c0 = cmd_total; e0 = err_total; b0 = busy_total;
        xfer(0, 0, 8'h01, 2);
        xfer(1, 0, 8'h57, 6);
        chk("t5 busy during write", int'(busy), 1);
        model_apply(0, 0, 8'h01, e_err, e_cmd, e_clr);
        wait_idle();
        chk("t5 err pulses", err_total - e0, 1);
        chk("t5 cmd pulses", cmd_total - c0, 1);
        chk("t5 busy cycles", busy_total - b0, 32);
        check_all("t5");

        // Reset in the middle of a fill
        run_vec(0, 0, 8'hC4, "t6_ac", e_err, e_cmd);
        run_vec(1, 0, 8'h51, "t6_q", e_err, e_cmd);
        run_vec(0, 0, 8'h0F, "t6_flags", e_err, e_cmd);
        b0 = busy_total;
        xfer(0, 0, 8'h01, 2);
        i = 0;
        while ((busy_total - b0) < 10 && i < 60) begin @(negedge clk); i++; end
        chk("t6 fill reached index 10", busy_total - b0, 10);
        reset = 1'b1;
        #1;
        chk("t6 busy after async reset", int'(busy), 0);
        chk("t6 cmd_valid after reset", int'(cmd_valid), 0);
        chk("t6 err_pulse after reset", int'(err_pulse), 0);
        model_reset();
        check_all("t6");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all("t6_post");

        // Randomized transfers against the model
        for (int k = 0; k < 200; k++) begin
            bit       rs, rw;
            bit [7:0] d;
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 15) == 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 24) == 0) begin rs = 0; rw = 0; d = 8'h01; end
            run_vec(rs, rw, d, $sformatf("rnd%0d", k), e_err, e_cmd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
